// File: rtl/ysyx_040750_mem_stage_reg.sv
// ysyx_040750_mem_stage_reg: pipeline register for the memory stage; issues one
// load/store per entry and forwards the response with zero added latency.
module ysyx_040750_mem_stage_reg #(
  parameter int PAYLOAD_W = 128,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                 I_sys_clk,
  input  logic                 I_rst_n,
  input  logic                 I_valid,
  output logic                 O_allowin,
  output logic                 O_valid,
  input  logic                 I_allowout,
  input  logic                 I_flush,
  input  logic [PAYLOAD_W-1:0] I_payload,
  output logic [PAYLOAD_W-1:0] O_payload,
  input  logic                 I_mem_rd,
  input  logic                 I_mem_wr,
  input  logic [ADDR_W-1:0]    I_addr,
  input  logic [DATA_W-1:0]    I_wdata,
  input  logic [STRB_W-1:0]    I_wstrb,
  output logic [ADDR_W-1:0]    O_addr,
  output logic [DATA_W-1:0]    O_wdata,
  output logic [STRB_W-1:0]    O_wstrb,
  output logic                 O_mem_rd_en,
  output logic                 O_mem_wr_en,
  input  logic                 I_mem_ready,
  input  logic                 I_mem_rvalid,
  input  logic [DATA_W-1:0]    I_mem_rdata,
  input  logic                 I_mem_bvalid,
  input  logic                 I_mem_err,
  output logic [DATA_W-1:0]    O_rdata,
  output logic                 O_err,
  output logic                 O_busy
);
  localparam logic [2:0] S_EMPTY = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  logic [2:0]           state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]    wstrb_q, wstrb_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 rd_q, rd_d, wr_q, wr_d, both_q, both_d, err_q, err_d;
  logic                 resp, accept;
  // rd_q selects which response channel completes the entry (read wins on conflict)
  always_comb begin
    resp = rd_q ? I_mem_rvalid : I_mem_bvalid;
    O_valid = ~I_flush & ((state_q == S_DONE) | ((state_q == S_WAIT) & resp));
    O_allowin = I_rst_n & ((state_q == S_EMPTY) | (O_valid & I_allowout));
    accept = I_valid & O_allowin & ~I_flush;
    O_rdata = ~O_valid ? '0 : (state_q == S_DONE) ? rdata_q : rd_q ? I_mem_rdata : '0;
    O_err = O_valid & ((state_q == S_DONE) ? err_q : (I_mem_err | both_q));
    O_mem_rd_en = (state_q == S_REQ) & rd_q;
    O_mem_wr_en = (state_q == S_REQ) & wr_q;
    O_busy = state_q != S_EMPTY;
    O_payload = payload_q;
    O_addr = addr_q;
    O_wdata = wdata_q;
    O_wstrb = wstrb_q;
  end
  always_comb begin
    state_d = state_q;
    payload_d = payload_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_d = rd_q;
    wr_d = wr_q;
    both_d = both_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      S_REQ: state_d = I_mem_ready ? (I_flush ? S_DRAIN : S_WAIT) : (I_flush ? S_EMPTY : S_REQ);
      S_WAIT:
        if (resp) begin
          state_d = (I_flush | I_allowout) ? S_EMPTY : S_DONE;
          rdata_d = rd_q ? I_mem_rdata : '0;
          err_d = I_mem_err | both_q;
        end else state_d = I_flush ? S_DRAIN : S_WAIT;
      S_DONE: state_d = (I_flush | I_allowout) ? S_EMPTY : S_DONE;
      S_DRAIN: state_d = resp ? S_EMPTY : S_DRAIN;
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      state_d = (I_mem_rd | I_mem_wr) ? S_REQ : S_DONE;
      payload_d = I_payload;
      addr_d = I_addr;
      wdata_d = I_wdata;
      wstrb_d = I_wstrb;
      rd_d = I_mem_rd;
      wr_d = I_mem_wr & ~I_mem_rd;
      both_d = I_mem_rd & I_mem_wr;
      rdata_d = '0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_EMPTY;
      payload_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      both_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      payload_q <= payload_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      both_q <= both_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ysyx_040750_mem_stage_reg.sv
// tb_ysyx_040750_mem_stage_reg: directed scenarios plus random traffic checked
// against an entry-level reference model.
module tb_ysyx_040750_mem_stage_reg;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid, allowout, flush, mem_rd, mem_wr, mem_ready, rvalid, bvalid, mem_err;
  logic [127:0] payload, o_payload;
  logic [63:0] addr, wdata, rdata, o_addr, o_wdata, o_rdata;
  logic [7:0] wstrb, o_wstrb;
  logic o_allowin, o_valid, o_rd_en, o_wr_en, o_err, o_busy;
  int n_chk = 0, n_pass = 0, rd_cnt = 0;
  bit m_ent, m_req, m_wait, m_drop, m_res, m_rd, m_wr, m_err;
  logic [127:0] m_pay;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0] m_wstrb;

  always #5 clk = ~clk;

  ysyx_040750_mem_stage_reg dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .O_allowin(o_allowin),
    .O_valid(o_valid), .I_allowout(allowout), .I_flush(flush),
    .I_payload(payload), .O_payload(o_payload), .I_mem_rd(mem_rd), .I_mem_wr(mem_wr),
    .I_addr(addr), .I_wdata(wdata), .I_wstrb(wstrb), .O_addr(o_addr),
    .O_wdata(o_wdata), .O_wstrb(o_wstrb), .O_mem_rd_en(o_rd_en), .O_mem_wr_en(o_wr_en),
    .I_mem_ready(mem_ready), .I_mem_rvalid(rvalid), .I_mem_rdata(rdata),
    .I_mem_bvalid(bvalid), .I_mem_err(mem_err), .O_rdata(o_rdata), .O_err(o_err),
    .O_busy(o_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic idle();
    valid = 1'b0; allowout = 1'b1; flush = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_ready = 1'b0; rvalid = 1'b0; bvalid = 1'b0; mem_err = 1'b0;
    payload = {$urandom, $urandom, $urandom, $urandom};
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
    wstrb = 8'($urandom);
  endtask

  task automatic model_reset();
    {m_ent, m_req, m_wait, m_drop, m_res, m_rd, m_wr, m_err} = '0;
  endtask

  // An entry is: waiting to issue (m_req), awaiting its response (m_wait, m_drop if killed),
  // or holding its finished result (m_res).
  function automatic logic exp_valid();
    return ~flush & (m_res | (m_wait & ~m_drop & (m_rd ? rvalid : bvalid)));
  endfunction

  task automatic model_step(input logic ev);
    logic acc, resp;
    resp = m_rd ? rvalid : bvalid;
    acc = valid & ~flush & (~m_ent | (ev & allowout));
    if (m_ent) begin
      if (m_req) begin
        if (mem_ready) begin m_req = 0; m_wait = 1; m_drop = flush; end
        else if (flush) m_ent = 0;
      end else if (m_wait) begin
        if (resp) begin
          if (m_drop | flush | allowout) m_ent = 0;
          else begin
            m_wait = 0; m_res = 1;
            m_rdata = m_rd ? rdata : 64'd0;
            m_err = mem_err | (m_rd & m_wr);
          end
        end else if (flush) m_drop = 1;
      end else if (m_res & (flush | allowout)) m_ent = 0;
    end
    if (!m_ent) model_reset();
    if (acc) begin
      m_ent = 1; m_rd = mem_rd; m_wr = mem_wr; m_req = mem_rd | mem_wr;
      m_wait = 0; m_drop = 0; m_res = ~(mem_rd | mem_wr); m_rdata = '0; m_err = 0;
      m_pay = payload; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    end
  endtask

  task automatic cyc();
    logic ev;
    #1;
    ev = exp_valid();
    check("valid", 128'(o_valid), 128'(ev));
    check("allowin", 128'(o_allowin), 128'(rst_n & (~m_ent | (ev & allowout))));
    check("rd_en", 128'(o_rd_en), 128'(m_req & m_rd));
    check("wr_en", 128'(o_wr_en), 128'(m_req & m_wr & ~m_rd));
    check("busy", 128'(o_busy), 128'(m_ent));
    if (ev) begin
      check("rdata", 128'(o_rdata), 128'(m_res ? m_rdata : (m_rd ? rdata : 64'd0)));
      check("err", 128'(o_err), 128'(m_res ? m_err : (mem_err | (m_rd & m_wr))));
    end
    if (m_ent) begin
      check("payload", o_payload, m_pay);
      check("addr", 128'(o_addr), 128'(m_addr));
      check("wdata", 128'(o_wdata), 128'(m_wdata));
      check("wstrb", 128'(o_wstrb), 128'(m_wstrb));
    end
    if (o_rd_en) rd_cnt++;
    model_step(ev);
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    #3;
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_allowin", 128'(o_allowin), 128'd0);
    check("rst_busy", 128'(o_busy), 128'd0);
    check("rst_strobes", 128'({o_rd_en, o_wr_en, o_err}), 128'd0);
    check("rst_payload", o_payload, 128'd0);
    check("rst_regs", {o_addr, o_wdata}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // back-to-back non-memory entries
    valid = 1'b1; payload = 128'hA5;
    for (int i = 0; i < 4; i++) cyc();
    check("nm_payload", o_payload, 128'hA5);
    idle(); cyc();
    // load: ready after 3 cycles, response 2 cycles after handshake
    valid = 1'b1; mem_rd = 1'b1; addr = 64'h8000_0000; rd_cnt = 0;
    cyc();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    cyc();
    rvalid = 1'b1; rdata = 64'h1122_3344_5566_7788;
    #1;
    check("ld_valid", 128'(o_valid), 128'd1);
    check("ld_rdata", 128'(o_rdata), 128'h1122_3344_5566_7788);
    cyc();
    rvalid = 1'b0;
    check("ld_rden_cycles", 128'(rd_cnt), 128'd4);
    // store held in DONE by back-pressure
    idle(); valid = 1'b1; mem_wr = 1'b1; wstrb = 8'h0F;
    cyc();
    valid = 1'b0; mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    bvalid = 1'b1; mem_err = 1'b1; allowout = 1'b0;
    cyc();
    bvalid = 1'b0; mem_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("st_hold_valid", 128'(o_valid), 128'd1);
      check("st_hold_err", 128'(o_err), 128'd1);
      check("st_hold_rdata", 128'(o_rdata), 128'd0);
      check("st_hold_allowin", 128'(o_allowin), 128'd0);
      cyc();
    end
    allowout = 1'b1; cyc();
    // flush while waiting swallows the response
    idle(); valid = 1'b1; mem_rd = 1'b1;
    cyc();
    valid = 1'b0; mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    flush = 1'b1; cyc(); flush = 1'b0;
    cyc();
    rvalid = 1'b1;
    #1;
    check("fl_valid", 128'(o_valid), 128'd0);
    cyc();
    rvalid = 1'b0;
    #1;
    check("fl_allowin", 128'(o_allowin), 128'd1);
    cyc();
    // read and write together: read only, error flagged
    idle(); valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1;
    cyc();
    valid = 1'b0;
    #1;
    check("both_rd_en", 128'(o_rd_en), 128'd1);
    check("both_wr_en", 128'(o_wr_en), 128'd0);
    mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    rvalid = 1'b1;
    #1;
    check("both_err", 128'(o_err), 128'd1);
    cyc();
    rvalid = 1'b0;
    // asynchronous reset during a request
    idle(); valid = 1'b1; mem_rd = 1'b1;
    cyc();
    valid = 1'b0;
    #2;
    check("pre_rst_rd_en", 128'(o_rd_en), 128'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_en", 128'(o_rd_en), 128'd0);
    check("async_rst_busy", 128'(o_busy), 128'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    cyc();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      valid = $urandom_range(9) < 6;
      mem_rd = 1'($urandom); mem_wr = 1'($urandom);
      mem_ready = 1'($urandom);
      rvalid = $urandom_range(9) < 3; bvalid = $urandom_range(9) < 3;
      mem_err = $urandom_range(3) == 0;
      flush = $urandom_range(11) == 0;
      allowout = $urandom_range(9) < 7;
      payload = {$urandom, $urandom, $urandom, $urandom};
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      wstrb = 8'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ysyx_040750_mem_stage_reg.md
YSYX_040750_MEM_STAGE_REG -- requirements
Module: ysyx_040750_mem_stage_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 128: width of pass-through pipeline payload (pc, rd, csr fields, etc.).
REQ-002 SHALL have parameter ADDR_W, default 64: memory address width.
REQ-003 SHALL have parameter DATA_W, default 64: memory data width, multiple of 8; STRB_W = DATA_W/8 is derived.
REQ-004 I_sys_clk  in  1  sole clock, rising edge.
REQ-005 I_rst_n  in  1  asynchronous, active-low reset.
REQ-006 I_valid  in  1  upstream entry valid; O_allowin  out  1  stage can accept.
REQ-007 O_valid  out  1  downstream entry valid; I_allowout  in  1  downstream accepts.
REQ-008 I_flush  in  1  kill current and incoming entry.
REQ-009 I_payload  in  PAYLOAD_W; O_payload  out  PAYLOAD_W  registered payload.
REQ-010 I_mem_rd, I_mem_wr  in  1 each  entry is load / store.
REQ-011 I_addr  in  ADDR_W; I_wdata  in  DATA_W; I_wstrb  in  STRB_W; O_addr, O_wdata, O_wstrb  out  same widths, registered.
REQ-012 O_mem_rd_en, O_mem_wr_en  out  1  request strobes; I_mem_ready  in  1  request accepted.
REQ-013 I_mem_rvalid  in  1; I_mem_rdata  in  DATA_W; I_mem_bvalid  in  1; I_mem_err  in  1  sampled with rvalid/bvalid.
REQ-014 O_rdata  out  DATA_W; O_err  out  1; O_busy  out  1  (state != EMPTY).

Function
REQ-015 States: EMPTY, REQ, WAIT, DONE, DRAIN; encoding free.
REQ-016 Accept = I_valid & O_allowin & ~I_flush; O_allowin = (EMPTY) | (O_valid & I_allowout); O_allowin = 0 in REQ, DRAIN, and in WAIT without response.
REQ-017 On accept: payload/addr/wdata/wstrb captured; next state REQ if I_mem_rd|I_mem_wr, else DONE.
REQ-018 I_mem_rd and I_mem_wr both high: read wins, write discarded, O_err set at completion.
REQ-019 REQ: O_mem_rd_en or O_mem_wr_en high (per captured type), held until I_mem_ready; handshake -> WAIT next cycle; strobe low in WAIT.
REQ-020 Responses only honoured in WAIT/DRAIN; rvalid/bvalid in other states ignored.
REQ-021 WAIT + matching response: O_valid = 1 same cycle (zero-cycle pass-through), O_rdata = I_mem_rdata, O_err = I_mem_err; if I_allowout, entry retires (next EMPTY, or new entry per REQ-017); else rdata/err latched, next DONE.
REQ-022 DONE: O_valid = 1, O_rdata/O_err from latch; I_allowout retires; back-to-back accept allowed same cycle.
REQ-023 Store completion: bvalid; O_rdata = 0.
REQ-024 Non-mem entry: O_rdata = 0, O_err = 0; 1-cycle latency EMPTY->DONE.
REQ-025 I_flush in REQ before handshake: strobe dropped next cycle, -> EMPTY; flush coincident with I_mem_ready: request counts as accepted, -> DRAIN.
REQ-026 I_flush in WAIT (no response that cycle) -> DRAIN; DRAIN discards next response, then EMPTY; O_valid = 0 throughout.
REQ-027 I_flush in DONE, or in WAIT with response: O_valid forced 0, entry discarded, -> EMPTY; no accept that cycle.
REQ-028 O_valid never high in EMPTY, REQ, DRAIN.
REQ-029 Latched outputs stable while O_valid & ~I_allowout.

Reset
REQ-030 I_rst_n low: immediately state EMPTY, all outputs and registers 0, mem strobes 0, asynchronously, independent of clock.
REQ-031 Reset mid-transaction abandons it; any later response seen in EMPTY ignored.
REQ-032 Release synchronous to clock edge; first accept possible first edge after release.

Verification
REQ-033 Non-mem: I_valid=1, payload=0xA5, I_allowout=1 -> O_valid next cycle, O_payload=0xA5, O_rdata=0, 1 entry/cycle sustained.
REQ-034 Load: addr=0x8000_0000, ready after 3 cycles, rvalid 2 cycles later with rdata=0x1122_3344_5566_7788 -> O_mem_rd_en high 4 cycles, O_valid same cycle as rvalid, O_rdata matches.
REQ-035 Store with I_allowout=0 at bvalid -> DONE, O_valid held, O_err=I_mem_err, O_allowin=0 until I_allowout=1.
REQ-036 Flush in WAIT, rvalid 2 cycles later -> O_valid stays 0, response swallowed, O_allowin=1 cycle after rvalid.
REQ-037 I_mem_rd=I_mem_wr=1 -> only O_mem_rd_en, O_err=1 at completion.
REQ-038 I_rst_n low in REQ between clock edges -> O_mem_rd_en=0 at once; subsequent rvalid ignored.
